// File: rtl/ps2_key_pkg.sv
// Shared scancodes, FSM encoding and held-key bookkeeping for the PS/2 paddle key controller.
package ps2_key_pkg;

  localparam int EV_CODE_W = 8;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_UPARR = 8'h75;
  localparam logic [7:0] SC_DNARR = 8'h72;

  localparam int TIMEOUT_CYC_DEF = 2_500_000;
  localparam int CNT_W_DEF       = 22;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } key_state_t;

  localparam int HK_W   = 0;
  localparam int HK_S   = 1;
  localparam int HK_I   = 2;
  localparam int HK_K   = 3;
  localparam int HK_UP  = 4;
  localparam int HK_DN  = 5;
  localparam int HK_NUM = 6;

  // Arrow keys only count with the E0 prefix; keypad 8/2 (same codes, no E0) are ignored.
  function automatic logic [HK_NUM-1:0] key_mask(input logic [7:0] code, input logic ext);
    logic [HK_NUM-1:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_W:    m[HK_W] = 1'b1;
        SC_S:    m[HK_S] = 1'b1;
        SC_I:    m[HK_I] = 1'b1;
        SC_K:    m[HK_K] = 1'b1;
        default: m = '0;
      endcase
    end else begin
      case (code)
        SC_UPARR: m[HK_UP] = 1'b1;
        SC_DNARR: m[HK_DN] = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_evt_buf.sv
// One-entry valid/ready holding register for decoded key events.
// A push into a full buffer that is not being popped is lost and flagged by a one-cycle drop pulse.
module ps2_evt_buf
  import ps2_key_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [EV_CODE_W-1:0] push_code,
  input  logic                 push_ext,
  input  logic                 push_brk,
  input  logic                 ready,
  output logic                 valid,
  output logic [EV_CODE_W-1:0] code,
  output logic                 ext,
  output logic                 brk,
  output logic                 drop
);

  logic pop;
  logic load;

  assign pop  = valid & ready;
  assign load = push & (~valid | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      code  <= '0;
      ext   <= 1'b0;
      brk   <= 1'b0;
      drop  <= 1'b0;
    end else begin
      drop <= push & ~load;
      if (load) begin
        valid <= 1'b1;
        code  <= push_code;
        ext   <= push_ext;
        brk   <= push_brk;
      end else if (pop) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Turns the PS/2 receiver byte stream into make/break events and resolved paddle commands.
//
//   state      | meaning
//   ST_IDLE    | no prefix pending; plain byte completes a make
//   ST_EXT     | E0 seen; waiting for F0 or the extended code
//   ST_BRK     | F0 seen; next byte completes a break
//   ST_EXT_BRK | E0 F0 seen; next byte completes an extended break
module ps2_key_ctrl
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       freeze,
  output logic       rx_en,
  output logic       p1_up,
  output logic       p1_dn,
  output logic       p2_up,
  output logic       p2_dn,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       ev_drop
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  key_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [HK_NUM-1:0] held, held_nxt;
  logic [1:0]        last_up, last_up_nxt;

  logic              byte_acc;
  logic              is_prefix;
  logic              done;
  logic              done_ext;
  logic              done_brk;
  logic              push;
  logic [HK_NUM-1:0] mask;

  assign byte_acc  = rx_done_tick & rx_en;
  assign is_prefix = (rx_data == SC_E0) | (rx_data == SC_F0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      held    <= '0;
      last_up <= '0;
      rx_en   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      held    <= held_nxt;
      last_up <= last_up_nxt;
      rx_en   <= ~freeze;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    held_nxt    = held;
    last_up_nxt = last_up;
    done        = 1'b0;
    done_ext    = 1'b0;
    done_brk    = 1'b0;
    push        = 1'b0;

    // Freeze wins over a byte arriving in the same cycle: the byte is dropped with the sequence.
    if (freeze) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      held_nxt  = '0;
    end else if (byte_acc) begin
      cnt_nxt = '0;
      case (state)
        ST_IDLE: begin
          if (rx_data == SC_E0) state_nxt = ST_EXT;
          else if (rx_data == SC_F0) state_nxt = ST_BRK;
          else done = 1'b1;
        end
        ST_EXT: begin
          state_nxt = ST_IDLE;
          if (rx_data == SC_F0) begin
            state_nxt = ST_EXT_BRK;
          end else if (rx_data != SC_E0) begin
            done     = 1'b1;
            done_ext = 1'b1;
          end
        end
        ST_BRK: begin
          state_nxt = ST_IDLE;
          if (!is_prefix) begin
            done     = 1'b1;
            done_brk = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          state_nxt = ST_IDLE;
          if (!is_prefix) begin
            done     = 1'b1;
            done_ext = 1'b1;
            done_brk = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (cnt == TO_LAST) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

    mask = key_mask(rx_data, done_ext);

    // A make of a key already held is typematic repeat: no event, last-pressed untouched.
    if (done) begin
      if (done_brk) begin
        held_nxt = held & ~mask;
        push     = 1'b1;
      end else if ((held & mask) == '0) begin
        held_nxt = held | mask;
        push     = 1'b1;
        if (mask[HK_W]) last_up_nxt[0] = 1'b1;
        if (mask[HK_S]) last_up_nxt[0] = 1'b0;
        if (mask[HK_I] | mask[HK_UP]) last_up_nxt[1] = 1'b1;
        if (mask[HK_K] | mask[HK_DN]) last_up_nxt[1] = 1'b0;
      end
    end
  end

  logic p1_up_h, p1_dn_h, p2_up_h, p2_dn_h;

  assign p1_up_h = held[HK_W];
  assign p1_dn_h = held[HK_S];
  assign p2_up_h = held[HK_I] | held[HK_UP];
  assign p2_dn_h = held[HK_K] | held[HK_DN];

  assign p1_up = p1_up_h & (~p1_dn_h | last_up[0]);
  assign p1_dn = p1_dn_h & (~p1_up_h | ~last_up[0]);
  assign p2_up = p2_up_h & (~p2_dn_h | last_up[1]);
  assign p2_dn = p2_dn_h & (~p2_up_h | ~last_up[1]);

  ps2_evt_buf u_evt_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_code (rx_data),
    .push_ext  (done_ext),
    .push_brk  (done_brk),
    .ready     (ev_ready),
    .valid     (ev_valid),
    .code      (ev_code),
    .ext       (ev_ext),
    .brk       (ev_brk),
    .drop      (ev_drop)
  );

endmodule
